// File: rtl/jk_cnt_pkg.sv
// Shared constants for the JK-flip-flop synchronous counter.
//   WIDTH_DEFAULT : default counter width
//   JK_*          : {J,K} action encodings applied to each flip-flop cell
package jk_cnt_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;

  typedef logic [1:0] jk_act_t;

  localparam jk_act_t JK_HOLD   = 2'b00;
  localparam jk_act_t JK_RESET  = 2'b01;
  localparam jk_act_t JK_SET    = 2'b10;
  localparam jk_act_t JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_cell.sv
// Single JK flip-flop storage cell.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, forces q=0
//   j,k : JK action inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q   : stored bit
//   qb  : complement of q, always valid, including during reset
module jk_ff_cell
  import jk_cnt_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  // JK state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (jk_act_t'({j, k}))
        JK_HOLD:   q <= q;
        JK_RESET:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter built from JK flip-flop cells.
// Optional parallel load compiled in with macro JK_CNT_LOAD_EN.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (dominates load and en)
//   en   : count enable
//   up   : 1 = increment, 0 = decrement
//   load : parallel-load strobe (JK_CNT_LOAD_EN only)
//   d    : parallel-load value (JK_CNT_LOAD_EN only)
//   q    : counter state
//   qb   : bitwise complement of q
//   tc   : combinational terminal count (about to wrap on this edge)
//   wrap : registered one-cycle pulse after a wrap-around edge
module jk_sync_counter
  import jk_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
`ifdef JK_CNT_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] d,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  jk_act_t jk_act [WIDTH];
  logic    load_now;

`ifdef JK_CNT_LOAD_EN
  assign load_now = load;
`else
  assign load_now = 1'b0;
`endif

  // Toggle-enable chain: bit i toggles when all lower bits sit at the
  // direction's terminal value (all ones counting up, all zeros counting down).
  always_comb begin : toggle_chain
    logic ones_run;
    logic zeros_run;
    ones_run  = 1'b1;
    zeros_run = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      jk_act[i] = (en & (up ? ones_run : zeros_run)) ? JK_TOGGLE : JK_HOLD;
`ifdef JK_CNT_LOAD_EN
      // Load overrides counting: J=d[i], K=~d[i]
      if (load) jk_act[i] = d[i] ? JK_SET : JK_RESET;
`endif
      ones_run  = ones_run  &  q[i];
      zeros_run = zeros_run & ~q[i];
    end
    tc = en & (up ? ones_run : zeros_run);
  end

  // One JK cell per state bit
  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (jk_act[g][1]),
      .k   (jk_act[g][0]),
      .q   (q[g]),
      .qb  (qb[g])
    );
  end

  // Wrap pulse: a terminal-count edge that was not replaced by a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc & ~load_now;
    end
  end

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed, scoreboard-checked bench for jk_sync_counter (WIDTH=4).
// Load scenarios are included when JK_CNT_LOAD_EN is defined.
module tb_jk_sync_counter;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] MAXV = '1;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic         wrap;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         ld;
  logic [W-1:0] dv;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;
  logic         wrap;

  int           vectors;
  int           miscompares;
  logic [W-1:0] model_q;
  exp_t         sb[$];

  jk_sync_counter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
`ifdef JK_CNT_LOAD_EN
    .load (ld),
    .d    (dv),
`endif
    .q    (q),
    .qb   (qb),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb.underflow", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".q"}, 16'(q), 16'(e.q));
      chk({e.tag, ".qb"}, 16'(qb), 16'(W'(~e.q)));
      chk({e.tag, ".wrap"}, 16'(wrap), 16'(e.wrap));
    end
  endtask

  // Called at a falling edge with inputs already driven; applies one rising edge.
  task automatic step(input string tag);
    exp_t         e;
    logic         exp_tc;
    logic [W-1:0] nq;
    #1;
    exp_tc = en && (up ? (model_q == MAXV) : (model_q == '0));
    chk({tag, ".tc"}, 16'(tc), 16'(exp_tc));
    if (ld)      nq = dv;
    else if (en) nq = up ? W'(model_q + 1) : W'(model_q - 1);
    else         nq = model_q;
    e.tag  = tag;
    e.q    = nq;
    e.wrap = exp_tc && !ld;
    sb.push_back(e);
    model_q = nq;
    @(posedge clk);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic count_up_to(input logic [W-1:0] target);
    en = 1'b1;
    up = 1'b1;
    for (int n = 0; n < 20 && model_q != target; n++) step("seek");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_q     = '0;
    rst = 1'b1;
    en  = 1'b1;
    up  = 1'b1;
    ld  = 1'b0;
    dv  = '0;

    // Reset without any clock edge, then across one edge with en=1
    #2;
    chk("rst.noclk.q", 16'(q), 16'h0);
    chk("rst.noclk.qb", 16'(qb), 16'hF);
    chk("rst.noclk.wrap", 16'(wrap), 16'h0);
    #7;
    chk("rst.edge.q", 16'(q), 16'h0);
    chk("rst.edge.qb", 16'(qb), 16'hF);
    chk("rst.edge.wrap", 16'(wrap), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Full up-count cycle 1..15,0 with wrap on return to 0
    for (int i = 0; i < 16; i++) step("up");

    // Down from 0: 15 (wrap), 14, 13
    up = 1'b0;
    for (int i = 0; i < 3; i++) step("down");

    // Direction change: 5,4,5 then hold for 3 edges
    count_up_to(4'd5);
    up = 1'b0;
    step("dir.down");
    up = 1'b1;
    step("dir.up");
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold.final", 16'(q), 16'd5);

`ifdef JK_CNT_LOAD_EN
    // Load at terminal count replaces the wrap
    count_up_to(4'd15);
    ld = 1'b1;
    dv = 4'd9;
    step("load.tc");
    ld = 1'b0;
    step("load.after");

    // Reset dominates load
    rst = 1'b1;
    ld  = 1'b1;
    dv  = 4'hA;
    @(posedge clk);
    #1;
    chk("load.rst.q", 16'(q), 16'h0);
    chk("load.rst.wrap", 16'(wrap), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    ld  = 1'b0;
    model_q = '0;
`endif

    // Asynchronous reset mid-count at q=7
    count_up_to(4'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.q", 16'(q), 16'h0);
    chk("midrst.qb", 16'(qb), 16'hF);
    chk("midrst.wrap", 16'(wrap), 16'h0);
    @(negedge clk);
    chk("midrst.edge.q", 16'(q), 16'h0);
    rst = 1'b0;
    model_q = '0;
    en = 1'b1;
    up = 1'b1;
    step("release");
    chk("release.q1", 16'(q), 16'h1);

    chk("sb.drained", 16'(sb.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
